// File: rtl/alu_arbiter_ctrl.sv
// Round-robin scheduler sharing one ALU between two valid/ready requesters.
// Optional build macro ALU_DIVZERO_CHECK_EN: divide/modulo by zero is answered locally with an error flag.
module alu_arbiter_ctrl #(
    parameter int              DATA_W  = 8,
    parameter int              OP_W    = 3,
    parameter int              ALU_LAT = 1,
    parameter logic [OP_W-1:0] OP_DIV  = 3'b100,
    parameter logic [OP_W-1:0] OP_MOD  = 3'b101
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_err_o,
    output logic [OP_W-1:0]   alu_ctrl_o,
    output logic [DATA_W-1:0] alu_data0_o,
    output logic [DATA_W-1:0] alu_data1_o,
    input  logic [DATA_W-1:0] alu_result_i
);

`ifdef ALU_DIVZERO_CHECK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                id_q;
    logic                rsp_valid_q;
    logic                err_q;
    logic [DATA_W-1:0]   result_q;
    logic [OP_W-1:0]     ctrl_q;
    logic [DATA_W-1:0]   data0_q;
    logic [DATA_W-1:0]   data1_q;

    logic                grant_id;
    logic                accept;
    logic                is_divzero;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    // Pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        grant_id     = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
        req0_ready_o = !rst_i && (state_q == IDLE) && req0_valid_i && !grant_id;
        req1_ready_o = !rst_i && (state_q == IDLE) && req1_valid_i && grant_id;
        accept       = req0_ready_o || req1_ready_o;
        sel_op       = grant_id ? req1_op_i : req0_op_i;
        sel_a        = grant_id ? req1_a_i  : req0_a_i;
        sel_b        = grant_id ? req1_b_i  : req0_b_i;
        is_divzero   = DZ_EN && ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q  <= grant_id;
                        ptr_q <= ~grant_id;
                        if (is_divzero) begin
                            // Answered locally; the ALU keeps its previous operation.
                            result_q    <= '1;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            ctrl_q  <= sel_op;
                            data0_q <= sel_a;
                            data1_q <= sel_b;
                            cnt_q   <= CNT_W'(ALU_LAT - 1);
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q    <= alu_result_i;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_err_o    = DZ_EN ? err_q : 1'b0;
    assign alu_ctrl_o   = ctrl_q;
    assign alu_data0_o  = data0_q;
    assign alu_data1_o  = data1_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl: table of single transactions plus hand-written corner sequences.
module tb_alu_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // Shared request payloads; each DUT has its own valids and responses.
    logic [2:0] op0 = '0, op1 = '0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic       v0 = 1'b0, v1 = 1'b0, rsp_ready = 1'b0;
    logic       rdy0, rdy1, rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_result, alu_d0, alu_d1, alu_res;
    logic [2:0] alu_ctrl;

    logic       v0_3 = 1'b0, v1_3 = 1'b0, rsp_ready_3 = 1'b1;
    logic       rdy0_3, rdy1_3, rsp_valid_3, rsp_id_3, rsp_err_3;
    logic [7:0] rsp_result_3, alu_d0_3, alu_d1_3, alu_res_3;
    logic [2:0] alu_ctrl_3;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a * b;
            3'b100:  return (b == 0) ? 8'hFF : a / b;
            3'b101:  return (b == 0) ? 8'hFF : a % b;
            default: return a & b;
        endcase
    endfunction

    assign alu_res   = alu_f(alu_ctrl, alu_d0, alu_d1);
    assign alu_res_3 = alu_f(alu_ctrl_3, alu_d0_3, alu_d1_3);

    alu_arbiter_ctrl #(.ALU_LAT(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .alu_ctrl_o(alu_ctrl), .alu_data0_o(alu_d0), .alu_data1_o(alu_d1), .alu_result_i(alu_res)
    );

    alu_arbiter_ctrl #(.ALU_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0_3), .req0_ready_o(rdy0_3), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1_3), .req1_ready_o(rdy1_3), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
        .rsp_valid_o(rsp_valid_3), .rsp_ready_i(rsp_ready_3), .rsp_id_o(rsp_id_3),
        .rsp_result_o(rsp_result_3), .rsp_err_o(rsp_err_3),
        .alu_ctrl_o(alu_ctrl_3), .alu_data0_o(alu_d0_3), .alu_data1_o(alu_d1_3), .alu_result_i(alu_res_3)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Waits (bounded) on u_dut for rsp_valid; lat counts negedges after the accept cycle.
    task automatic wait_rsp(output bit got, output int lat, output bit stray);
        got = 1'b0; lat = 0; stray = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin got = 1'b1; lat = c + 1; end
            else if (rdy0 || rdy1) stray = 1'b1;
        end
        check("rsp_seen", got, 1'b1);
    endtask

    typedef struct {
        logic       v0;
        logic [2:0] op0;
        logic [7:0] a0, b0;
        logic       v1;
        logic [2:0] op1;
        logic [7:0] a1, b1;
        logic       exp_id;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, stray, seen;
        int lat;

        vecs[0] = '{1'b1, 3'b001, 8'd20,  8'd10, 1'b0, 3'b000, 8'd0,  8'd0,  1'b0, 8'd30};
        vecs[1] = '{1'b0, 3'b000, 8'd0,   8'd0,  1'b1, 3'b010, 8'd8,  8'd8,  1'b1, 8'd0};
        vecs[2] = '{1'b1, 3'b011, 8'd12,  8'd2,  1'b1, 3'b010, 8'd8,  8'd8,  1'b0, 8'd24};
        vecs[3] = '{1'b1, 3'b011, 8'd12,  8'd2,  1'b1, 3'b010, 8'd8,  8'd8,  1'b1, 8'd0};
        vecs[4] = '{1'b1, 3'b001, 8'd5,   8'd6,  1'b1, 3'b011, 8'd3,  8'd4,  1'b0, 8'd11};
        vecs[5] = '{1'b1, 3'b001, 8'd5,   8'd6,  1'b1, 3'b011, 8'd3,  8'd4,  1'b1, 8'd12};
        vecs[6] = '{1'b1, 3'b001, 8'd5,   8'd6,  1'b1, 3'b011, 8'd3,  8'd4,  1'b0, 8'd11};
        vecs[7] = '{1'b1, 3'b001, 8'd5,   8'd6,  1'b1, 3'b011, 8'd3,  8'd4,  1'b1, 8'd12};
        vecs[8] = '{1'b1, 3'b001, 8'd200, 8'd100,1'b0, 3'b000, 8'd0,  8'd0,  1'b0, 8'd44};
        vecs[9] = '{1'b0, 3'b000, 8'd0,   8'd0,  1'b1, 3'b010, 8'd3,  8'd5,  1'b1, 8'hFE};

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 8'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_alu_ctrl", alu_ctrl, 3'd0);
        check("rst_alu_data", {alu_d0, alu_d1}, 16'd0);
        check("rst_ready", {rdy0, rdy1}, 2'b00);
        @(negedge clk); rst = 1'b0;

        // Table-driven single transactions with rsp_ready held high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v0 = vecs[i].v0; op0 = vecs[i].op0; a0 = vecs[i].a0; b0 = vecs[i].b0;
            v1 = vecs[i].v1; op1 = vecs[i].op1; a1 = vecs[i].a1; b1 = vecs[i].b1;
            rsp_ready = 1'b1;
            #1;
            check("vec_ready0", rdy0, !vecs[i].exp_id);
            check("vec_ready1", rdy1, vecs[i].exp_id);
            wait_rsp(got, lat, stray);
            check("vec_latency", lat, 2);
            check("vec_no_stray_ready", stray, 1'b0);
            check("vec_id", rsp_id, vecs[i].exp_id);
            check("vec_result", rsp_result, vecs[i].exp_res);
            check("vec_err", rsp_err, 1'b0);
            $display("vec %0d: id=%0d result=%0d lat=%0d", i, rsp_id, rsp_result, lat);
        end

        // Back-pressure: response held for 5 cycles, next accept right after handshake
        @(negedge clk);
        v0 = 1'b1; op0 = 3'b001; a0 = 8'd1; b0 = 8'd2;
        v1 = 1'b1; op1 = 3'b010; a1 = 8'd9; b1 = 8'd4;
        rsp_ready = 1'b0;
        #1; check("bp_ready0", rdy0, 1'b1);
        wait_rsp(got, lat, stray);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("bp_hold_valid", rsp_valid, 1'b1);
            check("bp_hold_result", rsp_result, 8'd3);
            check("bp_hold_id", rsp_id, 1'b0);
            check("bp_hold_readys", {rdy0, rdy1}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_valid_cleared", rsp_valid, 1'b0);
        check("bp_next_ready1", rdy1, 1'b1);
        check("bp_next_ready0", rdy0, 1'b0);
        @(negedge clk); v0 = 1'b0; v1 = 1'b0;
        #1;
        wait_rsp(got, lat, stray);
        check("bp_second_id", rsp_id, 1'b1);
        check("bp_second_result", rsp_result, 8'd5);
        $display("backpressure: second id=%0d result=%0d", rsp_id, rsp_result);

        // ALU_LAT=3 instance: operands held three cycles, response at T+4
        @(negedge clk);
        op1 = 3'b100; a1 = 8'd7; b1 = 8'd3; v1_3 = 1'b1;
        #1; check("lat3_ready1", rdy1_3, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); v1_3 = 1'b0; #1;
            if (k < 4) begin
                check("lat3_no_rsp", rsp_valid_3, 1'b0);
                check("lat3_alu_ctrl", alu_ctrl_3, 3'b100);
                check("lat3_alu_data", {alu_d0_3, alu_d1_3}, {8'd7, 8'd3});
            end else begin
                check("lat3_rsp_valid", rsp_valid_3, 1'b1);
                check("lat3_result", rsp_result_3, 8'd2);
                check("lat3_id", rsp_id_3, 1'b1);
            end
        end
        $display("lat3: id=%0d result=%0d", rsp_id_3, rsp_result_3);

        // Asynchronous reset mid-operation
        @(negedge clk);
        v0 = 1'b1; op0 = 3'b001; a0 = 8'd4; b0 = 8'd5;
        #1; check("arst_ready0", rdy0, 1'b1);
        @(negedge clk); v0 = 1'b0; #1;
        check("arst_issued_ctrl", alu_ctrl, 3'b001);
        #2 rst = 1'b1;
        #1;
        check("arst_alu_ctrl", alu_ctrl, 3'd0);
        check("arst_alu_data", {alu_d0, alu_d1}, 16'd0);
        check("arst_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b000);
        check("arst_rsp_result", rsp_result, 8'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("arst_no_rsp", seen, 1'b0);
        @(negedge clk);
        v0 = 1'b1; op0 = 3'b011; a0 = 8'd3; b0 = 8'd3;
        v1 = 1'b1; op1 = 3'b001; a1 = 8'd1; b1 = 8'd1;
        #1;
        check("arst_ptr_ready0", rdy0, 1'b1);
        check("arst_ptr_ready1", rdy1, 1'b0);
        wait_rsp(got, lat, stray);
        v0 = 1'b0; v1 = 1'b0;
        check("arst_after_id", rsp_id, 1'b0);
        check("arst_after_result", rsp_result, 8'd9);
        $display("after reset: id=%0d result=%0d", rsp_id, rsp_result);

`ifdef ALU_DIVZERO_CHECK_EN
        // Divide by zero answered locally, ALU keeps the last issued op (011, 3, 3)
        @(negedge clk);
        v0 = 1'b1; op0 = 3'b100; a0 = 8'd7; b0 = 8'd0;
        #1; check("dz_ready0", rdy0, 1'b1);
        @(negedge clk); v0 = 1'b0; #1;
        check("dz_rsp_valid", rsp_valid, 1'b1);
        check("dz_result", rsp_result, 8'hFF);
        check("dz_err", rsp_err, 1'b1);
        check("dz_id", rsp_id, 1'b0);
        check("dz_alu_ctrl", alu_ctrl, 3'b011);
        check("dz_alu_data", {alu_d0, alu_d1}, {8'd3, 8'd3});
        $display("divzero: result=%0h err=%0d", rsp_result, rsp_err);
        @(negedge clk);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Two-requester scheduler that shares a single 8-bit ALU instance (alu_top) between independent clients. It accepts operation requests through a valid/ready handshake and arbitrates round-robin. It registers the operands onto the ALU inputs, waits a fixed ALU latency, then captures the result and returns it with the requester ID through a response handshake. The block sits between the client logic and alu_top, and is the only driver of the ALU ctrl/data inputs.

Parameters:
DATA_W, 8, operand/result width
OP_W, 3, ALU opcode width
ALU_LAT, 1, cycles operands are held before alu_result_i is sampled; legal range 1..15
OP_DIV, 3'b100, division opcode (divide-by-zero check only)
OP_MOD, 3'b101, modulo opcode (divide-by-zero check only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req0_valid_i  in  1  requester 0 has an operation
req0_ready_o  out  1  requester 0 request accepted this cycle
req0_op_i  in  OP_W  requester 0 opcode
req0_a_i  in  DATA_W  requester 0 operand A
req0_b_i  in  DATA_W  requester 0 operand B
req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i  same as requester 0, for requester 1
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  consumer takes response
rsp_id_o  out  1  requester ID of the response
rsp_result_o  out  DATA_W  ALU result
rsp_err_o  out  1  error flag (see Optional Feature)
alu_ctrl_o  out  OP_W  to alu_top ctrl_i
alu_data0_o  out  DATA_W  to alu_top data0_i
alu_data1_o  out  DATA_W  to alu_top data1_i
alu_result_i  in  DATA_W  from alu_top result_o

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: all outputs 0. State is IDLE, the round-robin pointer is 0, and the latency counter is 0.
- States are IDLE, EXEC and RESP.
- Grant (combinational):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester selected by the pointer is granted.
- reqN_ready_o = (state==IDLE) && grant==N && reqN_valid_i. At most one ready is high per cycle, and it is never high outside IDLE.
- Accept (in IDLE, on reqN_valid_i && reqN_ready_o):
  - op/a/b are registered onto alu_ctrl_o/alu_data0_o/alu_data1_o.
  - The ID is stored.
  - The pointer is set to the other requester.
  - The counter is loaded with ALU_LAT-1, and the state moves to EXEC.
- EXEC:
  - alu_* outputs are held stable.
  - If counter != 0, the counter decrements.
  - If counter == 0, alu_result_i is sampled into rsp_result_o, rsp_valid_o is set, and the state moves to RESP.
- RESP:
  - rsp_valid_o, rsp_id_o, rsp_result_o and rsp_err_o are held stable while rsp_ready_i is low.
  - On rsp_valid_o && rsp_ready_i, rsp_valid_o clears next cycle and the state moves to IDLE.
- Latency and throughput:
  - For an accept in cycle T, rsp_valid_o first asserts in cycle T+1+ALU_LAT.
  - The next accept is possible no earlier than the cycle after the response handshake.
- alu_* outputs keep the last issued operation after completion, until the next accept.
- Opcodes are passed to the ALU unmodified; no width extension. The result is whatever the ALU returns (8-bit truncated).
- Reset asserted mid-operation aborts immediately:
  - No response is produced for the aborted request.
  - The pointer returns to 0.
- Inputs of a non-granted requester are ignored. A requester that deasserts valid before ready is not served.

Optional Feature:
Macro: ALU_DIVZERO_CHECK_EN
- Defined:
  - An accepted op equal to OP_DIV or OP_MOD with operand B == 0 is not issued: alu_* outputs are unchanged.
  - The state goes directly to RESP with rsp_result_o=8'hFF and rsp_err_o=1. rsp_valid_o asserts in cycle T+1.
  - All other ops set rsp_err_o=0.
- Undefined:
  - All ops are forwarded to the ALU unconditionally.
  - rsp_err_o is tied to 0.

Test Plan:
1. ALU_LAT=1, req0 op=001 a=20 b=10 alone, rsp_ready_i=1 -> req0_ready_o high in T; rsp_valid_o in T+2 with result 30, id 0, err 0.
2. After reset, req0 (op=011, 12, 2) and req1 (op=010, 8, 8) valid in the same cycle -> req0 served first (result 24, id 0) with req1_ready_o low throughout; then req1 served (result 0, id 1).
3. Both requesters continuously valid for 4 ops -> response IDs 0,1,0,1.
4. Response back-pressure: rsp_ready_i low for 5 cycles -> rsp_valid_o/result/id held stable, both ready signals low; after handshake, IDLE and next accept one cycle later.
5. ALU_LAT=3, req1 op=100 a=7 b=3 -> alu_* stable 3 cycles; rsp at T+4 with result 2.
6. Async rst_i pulse during EXEC -> all outputs 0 immediately without a clock edge; no response after release; the next simultaneous request grants req0.
   Same bench with ALU_DIVZERO_CHECK_EN: op=100 a=7 b=0 -> rsp at T+1 with result 8'hFF, err 1, alu_ctrl_o unchanged.
